vga_dither_out: RTL and testbench

- Parametrised ordered-dither and output-register stage between the raybox colour outputs and board DAC pins.
- Reduces CHANNELS colour channels from IN_BITS to OUT_BITS using a Bayer threshold matrix, with optional temporal rotation driven by an internal frame counter.
- Registers hsync/vsync alongside the colour so sync and colour stay aligned.
- Replaces ad-hoc per-board dither logic in the top-level wrappers.

---
 rtl/raybox_video_pkg.sv | 39 +++
 rtl/dither_threshold.sv | 32 +++
 rtl/vga_dither_out.sv | 120 ++++++++++++
 tb/tb_vga_dither_out.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/raybox_video_pkg.sv
// Shared video constants: dither mode encoding, Bayer threshold tables
// and the threshold lookup helper used by the dither stage.
package raybox_video_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC    = 2'd0,
        MODE_STATIC   = 2'd1,
        MODE_TEMPORAL = 2'd2,
        MODE_RSVD     = 2'd3
    } dither_mode_e;

    // Element (x,y) of an NxN table lives at index y*N + x, LSB first.
    localparam logic [7:0] BAYER2 = {2'd1, 2'd3, 2'd2, 2'd0};

    localparam logic [63:0] BAYER4 = {
        4'd5,  4'd13, 4'd7,  4'd15,
        4'd9,  4'd1,  4'd11, 4'd3,
        4'd6,  4'd14, 4'd4,  4'd12,
        4'd10, 4'd2,  4'd8,  4'd0
    };

    // Threshold for matrix order 1 (2x2) or 2 (4x4); x/y use only their low order bits.
    function automatic logic [3:0] bayer_threshold(input int unsigned order,
                                                   input logic [1:0]  x,
                                                   input logic [1:0]  y);
        int unsigned idx;
        logic [3:0]  t;
        t = '0;
        if (order == 1) begin
            idx = {30'd0, y[0], x[0]};
            t   = {2'b00, BAYER2[idx*2 +: 2]};
        end else begin
            idx = {28'd0, y, x};
            t   = BAYER4[idx*4 +: 4];
        end
        return t;
    endfunction

endpackage

// File: rtl/dither_threshold.sv
// Combinational Bayer threshold lookup with optional per-frame rotation.
module dither_threshold
    import raybox_video_pkg::*;
#(
    parameter int unsigned MATRIX_LOG2 = 1
) (
    input  logic [MATRIX_LOG2-1:0]   px_lsb_i,
    input  logic [MATRIX_LOG2-1:0]   py_lsb_i,
    input  logic [2*MATRIX_LOG2-1:0] frame_cnt_i,
    input  dither_mode_e             mode_q_i,
    output logic [2*MATRIX_LOG2-1:0] thresh_o
);

    logic [1:0]               x_ext;
    logic [1:0]               y_ext;
    logic [3:0]               t_full;
    logic [2*MATRIX_LOG2-1:0] t_base;

    // Look up the matrix entry and rotate it by the frame counter in temporal mode.
    always_comb begin
        x_ext = '0;
        y_ext = '0;
        x_ext[MATRIX_LOG2-1:0] = px_lsb_i;
        y_ext[MATRIX_LOG2-1:0] = py_lsb_i;
        t_full = bayer_threshold(MATRIX_LOG2, x_ext, y_ext);
        t_base = t_full[2*MATRIX_LOG2-1:0];
        // Addition wraps at the counter width, giving the mod-M2 rotation.
        if (mode_q_i == MODE_TEMPORAL) thresh_o = t_base + frame_cnt_i;
        else                           thresh_o = t_base;
    end

endmodule

// File: rtl/vga_dither_out.sv
// Ordered-dither and output register stage between the renderer colour
// outputs and the board DAC pins; sync signals are registered alongside.
module vga_dither_out
    import raybox_video_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned IN_BITS     = 2,
    parameter int unsigned OUT_BITS    = 1,
    parameter int unsigned MATRIX_LOG2 = 1,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pix_en,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*IN_BITS-1:0]  in_rgb,
    input  logic                         in_blank,
    input  logic                         in_hsync,
    input  logic                         in_vsync,
    input  logic [MATRIX_LOG2-1:0]       px_lsb,
    input  logic [MATRIX_LOG2-1:0]       py_lsb,
    output logic [CHANNELS*OUT_BITS-1:0] out_rgb,
    output logic                         out_hsync,
    output logic                         out_vsync,
    output logic [2*MATRIX_LOG2-1:0]     frame_phase
);

    localparam int unsigned PH_W  = 2 * MATRIX_LOG2;
    localparam int unsigned M2    = 1 << PH_W;
    localparam int unsigned S_W   = OUT_BITS + PH_W;
    localparam int unsigned NV    = 1 << IN_BITS;
    localparam int unsigned SHIFT = IN_BITS - OUT_BITS;

    // Scaled value s for every input code, so no divider exists in hardware.
    function automatic logic [S_W*NV-1:0] build_s_table();
        logic [S_W*NV-1:0] tbl;
        tbl = '0;
        for (int unsigned v = 0; v < NV; v++)
            tbl[v*S_W +: S_W] = S_W'((v * ((1 << OUT_BITS) - 1) * M2) / ((1 << IN_BITS) - 1));
        return tbl;
    endfunction

    localparam logic [S_W*NV-1:0] S_TABLE = build_s_table();

    logic [CHANNELS*OUT_BITS-1:0] rgb_q, rgb_d;
    logic                         hs_q, vs_q, vs_hist_q;
    logic [PH_W-1:0]              phase_q, phase_d;
    dither_mode_e                 mode_q, mode_d;
    logic [PH_W-1:0]              thresh;
    logic                         vs_start;

    dither_threshold #(
        .MATRIX_LOG2(MATRIX_LOG2)
    ) u_thresh (
        .px_lsb_i   (px_lsb),
        .py_lsb_i   (py_lsb),
        .frame_cnt_i(phase_q),
        .mode_q_i   (mode_q),
        .thresh_o   (thresh)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [IN_BITS-1:0]  v;
        logic [S_W-1:0]      s;
        logic [OUT_BITS-1:0] q;
        logic [PH_W-1:0]     r;
        logic [OUT_BITS-1:0] chan_d;

        // Quantise one channel: dither against the threshold or truncate, then blank.
        always_comb begin
            v = in_rgb[c*IN_BITS +: IN_BITS];
            s = S_TABLE[v*S_W +: S_W];
            q = s[S_W-1:PH_W];
            r = s[PH_W-1:0];
            case (mode_q)
                MODE_STATIC, MODE_TEMPORAL: chan_d = q + OUT_BITS'(r > thresh);
                default:                    chan_d = v[IN_BITS-1:SHIFT];
            endcase
            if (in_blank) chan_d = '0;
        end

        assign rgb_d[c*OUT_BITS +: OUT_BITS] = chan_d;
    end

    // Detect the start of a vsync pulse; counter and mode advance only there.
    always_comb begin
        vs_start = (in_vsync == SYNC_ACTIVE) && (vs_hist_q != SYNC_ACTIVE);
        phase_d  = phase_q;
        mode_d   = mode_q;
        if (vs_start) begin
            phase_d = phase_q + PH_W'(1);
            mode_d  = dither_mode_e'(mode);
        end
    end

    // Output, sync, frame counter and mode registers, advanced once per pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q     <= '0;
            hs_q      <= ~SYNC_ACTIVE;
            vs_q      <= ~SYNC_ACTIVE;
            vs_hist_q <= ~SYNC_ACTIVE;
            phase_q   <= '0;
            mode_q    <= dither_mode_e'(mode);
        end else if (pix_en) begin
            rgb_q     <= rgb_d;
            hs_q      <= in_hsync;
            vs_q      <= in_vsync;
            vs_hist_q <= in_vsync;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
        end
    end

    assign out_rgb     = rgb_q;
    assign out_hsync   = hs_q;
    assign out_vsync   = vs_q;
    assign frame_phase = phase_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// Directed self-checking bench for vga_dither_out: default 2x2 configuration
// plus a 4x4 / 4-bit-to-2-bit instance for the wide-parameter cases.
module tb_vga_dither_out;

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic [1:0] mode;
    logic       in_blank;
    logic       in_hsync;
    logic       in_vsync;

    logic [5:0] in_rgb;
    logic       px, py;
    logic [2:0] out_rgb;
    logic       out_hsync, out_vsync;
    logic [1:0] frame_phase;

    logic [11:0] in_rgb2;
    logic [1:0]  px2, py2;
    logic [5:0]  out_rgb2;
    logic        out_hsync2, out_vsync2;
    logic [3:0]  frame_phase2;

    int checks;
    int failures;

    vga_dither_out dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
        .in_rgb(in_rgb), .in_blank(in_blank), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .px_lsb(px), .py_lsb(py),
        .out_rgb(out_rgb), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .frame_phase(frame_phase)
    );

    vga_dither_out #(
        .CHANNELS(3), .IN_BITS(4), .OUT_BITS(2), .MATRIX_LOG2(2), .SYNC_ACTIVE(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
        .in_rgb(in_rgb2), .in_blank(in_blank), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .px_lsb(px2), .py_lsb(py2),
        .out_rgb(out_rgb2), .out_hsync(out_hsync2), .out_vsync(out_vsync2),
        .frame_phase(frame_phase2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        reset = 1'b1;
        mode  = m;
        step();
        reset = 1'b0;
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b0;
        step();
        in_vsync = 1'b1;
        step();
    endtask

    task automatic test_reset();
        // Reset coinciding with a vsync falling edge: reset must win.
        pix_en = 1'b1; in_rgb = 6'h3f; in_hsync = 1'b0; in_vsync = 1'b0;
        do_reset(2'd1);
        checks++; if (out_rgb !== 3'b000) begin failures++; $display("FAIL reset_rgb got=%0h exp=0", out_rgb); end
        checks++; if (out_hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%0b exp=1", out_hsync); end
        checks++; if (out_vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%0b exp=1", out_vsync); end
        checks++; if (frame_phase !== 2'd0) begin failures++; $display("FAIL reset_vs_edge_phase got=%0d exp=0", frame_phase); end
        in_rgb = 6'h00; in_hsync = 1'b1; in_vsync = 1'b1; in_blank = 1'b0;
        step();
        checks++; if (out_rgb !== 3'b000) begin failures++; $display("FAIL idle_rgb got=%0h exp=0", out_rgb); end
        checks++; if (out_hsync !== 1'b1 || out_vsync !== 1'b1) begin failures++; $display("FAIL idle_sync got=%0b%0b exp=11", out_hsync, out_vsync); end
        checks++; if (frame_phase !== 2'd0) begin failures++; $display("FAIL idle_phase got=%0d exp=0", frame_phase); end
        checks++; if (out_rgb2 !== 6'h00 || frame_phase2 !== 4'd0) begin failures++; $display("FAIL idle_wide got=%0h/%0d exp=0/0", out_rgb2, frame_phase2); end
    endtask

    task automatic test_static();
        logic [1:0] vals [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
        logic [3:0] pat  [4] = '{4'b1001, 4'b1000, 4'b1111, 4'b0000};
        logic [3:0] p;
        logic       e;
        do_reset(2'd1);
        for (int k = 0; k < 4; k++) begin
            p = pat[k];
            for (int i = 0; i < 4; i++) begin
                in_rgb = {3{vals[k]}};
                px = i[0]; py = i[1];
                step();
                e = p[3-i];
                checks++;
                if (out_rgb !== {3{e}}) begin
                    failures++;
                    $display("FAIL static v=%0d x=%0d y=%0d got=%0b exp=%0b", vals[k], i % 2, i / 2, out_rgb, {3{e}});
                end
            end
        end
    endtask

    task automatic test_temporal();
        logic [3:0] p;
        logic       e;
        do_reset(2'd2);
        in_rgb = {3{2'b01}};
        vsync_pulse();
        checks++; if (frame_phase !== 2'd1) begin failures++; $display("FAIL temporal_phase1 got=%0d exp=1", frame_phase); end
        p = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            px = i[0]; py = i[1];
            step();
            e = p[3-i];
            checks++;
            if (out_rgb !== {3{e}}) begin
                failures++;
                $display("FAIL temporal_ph1 x=%0d y=%0d got=%0b exp=%0b", i % 2, i / 2, out_rgb, {3{e}});
            end
        end
        for (int n = 0; n < 3; n++) vsync_pulse();
        checks++; if (frame_phase !== 2'd0) begin failures++; $display("FAIL temporal_wrap got=%0d exp=0", frame_phase); end
        p = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            px = i[0]; py = i[1];
            step();
            e = p[3-i];
            checks++;
            if (out_rgb !== {3{e}}) begin
                failures++;
                $display("FAIL temporal_ph0 x=%0d y=%0d got=%0b exp=%0b", i % 2, i / 2, out_rgb, {3{e}});
            end
        end
    endtask

    task automatic test_pix_en();
        do_reset(2'd1);
        px = 1'b0; py = 1'b0;
        pix_en = 1'b1; in_rgb = {3{2'b11}}; in_hsync = 1'b0; in_vsync = 1'b0;
        step();
        checks++; if (out_rgb !== 3'b111 || out_hsync !== 1'b0 || out_vsync !== 1'b0) begin
            failures++; $display("FAIL en_first got=%0b h=%0b v=%0b exp=111 h=0 v=0", out_rgb, out_hsync, out_vsync); end
        pix_en = 1'b0; in_rgb = 6'h00; in_hsync = 1'b1; in_vsync = 1'b1;
        step();
        checks++; if (out_rgb !== 3'b111 || out_hsync !== 1'b0 || out_vsync !== 1'b0) begin
            failures++; $display("FAIL en_hold1 got=%0b h=%0b v=%0b exp=111 h=0 v=0", out_rgb, out_hsync, out_vsync); end
        in_rgb = {3{2'b10}};
        step();
        checks++; if (out_rgb !== 3'b111 || out_hsync !== 1'b0 || out_vsync !== 1'b0) begin
            failures++; $display("FAIL en_hold2 got=%0b h=%0b v=%0b exp=111 h=0 v=0", out_rgb, out_hsync, out_vsync); end
        pix_en = 1'b1; in_rgb = 6'h00;
        step();
        checks++; if (out_rgb !== 3'b000 || out_hsync !== 1'b1 || out_vsync !== 1'b1) begin
            failures++; $display("FAIL en_resume got=%0b h=%0b v=%0b exp=000 h=1 v=1", out_rgb, out_hsync, out_vsync); end
        checks++; if (frame_phase !== 2'd1) begin failures++; $display("FAIL en_phase got=%0d exp=1", frame_phase); end
    endtask

    task automatic test_mode_switch();
        do_reset(2'd1);
        mode = 2'd0;
        in_rgb = {3{2'b10}};
        px = 1'b0; py = 1'b0; step();
        checks++; if (out_rgb !== 3'b111) begin failures++; $display("FAIL msw_pre00 got=%0b exp=111", out_rgb); end
        px = 1'b1; py = 1'b0; step();
        checks++; if (out_rgb !== 3'b000) begin failures++; $display("FAIL msw_pre10 got=%0b exp=000", out_rgb); end
        vsync_pulse();
        for (int i = 0; i < 4; i++) begin
            px = i[0]; py = i[1];
            in_rgb = {3{2'b10}};
            step();
            checks++; if (out_rgb !== 3'b111) begin failures++; $display("FAIL msw_trunc_v2 i=%0d got=%0b exp=111", i, out_rgb); end
            in_rgb = {3{2'b01}};
            step();
            checks++; if (out_rgb !== 3'b000) begin failures++; $display("FAIL msw_trunc_v1 i=%0d got=%0b exp=000", i, out_rgb); end
        end
    endtask

    task automatic test_blank();
        do_reset(2'd1);
        in_blank = 1'b1; in_hsync = 1'b0;
        in_rgb = 6'h3f; in_rgb2 = 12'hfff;
        for (int i = 0; i < 4; i++) begin
            px = i[0]; py = i[1]; px2 = i[1:0]; py2 = i[1:0];
            step();
            checks++; if (out_rgb !== 3'b000 || out_rgb2 !== 6'h00) begin
                failures++; $display("FAIL blank_rgb i=%0d got=%0h/%0h exp=0/0", i, out_rgb, out_rgb2); end
        end
        checks++; if (out_hsync !== 1'b0) begin failures++; $display("FAIL blank_hsync got=%0b exp=0", out_hsync); end
        in_blank = 1'b0; in_hsync = 1'b1;
        step();
    endtask

    task automatic test_wide();
        int         b4 [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
        int         twos;
        logic [1:0] e;
        do_reset(2'd1);
        in_rgb2 = {3{4'h5}};
        for (int i = 0; i < 16; i++) begin
            px2 = i[1:0]; py2 = i[3:2];
            step();
            checks++; if (out_rgb2 !== {3{2'd1}}) begin
                failures++; $display("FAIL wide_v5 i=%0d got=%0h exp=%0h", i, out_rgb2, {3{2'd1}}); end
        end
        twos = 0;
        in_rgb2 = {3{4'h6}};
        for (int i = 0; i < 16; i++) begin
            px2 = i[1:0]; py2 = i[3:2];
            step();
            e = (b4[i] < 3) ? 2'd2 : 2'd1;
            if (out_rgb2[1:0] == 2'd2) twos++;
            checks++; if (out_rgb2 !== {3{e}}) begin
                failures++; $display("FAIL wide_v6 i=%0d got=%0h exp=%0h", i, out_rgb2, {3{e}}); end
        end
        checks++; if (twos !== 3) begin failures++; $display("FAIL wide_v6_count got=%0d exp=3", twos); end
    endtask

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; reset = 1'b0; pix_en = 1'b1; mode = 2'd0;
        in_blank = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
        in_rgb = '0; px = 1'b0; py = 1'b0;
        in_rgb2 = '0; px2 = '0; py2 = '0;
        test_reset();
        test_static();
        test_temporal();
        test_pix_en();
        test_mode_switch();
        test_blank();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
